lt_timer_bank: RTL

Parametrised bank of independent timeout counters for the USB4 link-training logic. It replaces fixed, per-purpose timeout flags with NUM_CH programmable channels. Each channel has a run-time limit, a tick source (base clock or an internal prescaled slow tick), a one-shot or periodic mode, and a synchronous clear. It sits beside the LTSSM and sideband blocks and runs entirely on the sideband clock, so no second slow clock domain is needed.

---
 rtl/lt_timer_pkg.sv | 11 +
 rtl/lt_timer_ch.sv | 46 ++++
 rtl/lt_timer_bank.sv | 45 ++++
 3 files changed

// File: rtl/lt_timer_pkg.sv
// lt_timer_pkg: shared tick/mode encodings and default LTSSM timeout limits
package lt_timer_pkg;
  typedef enum logic {TICK_BASE = 1'b0, TICK_SLOW = 1'b1} tick_sel_e;
  typedef enum logic {MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1} mode_e;
  localparam int TDISCONNECT_RX = 14;
  localparam int TCONNECT_RX = 25;
  localparam int TTRAINING_ERROR = 500;
  localparam int TDISABLED = 10;
  localparam int TGEN4_TS1 = 400;
  localparam int TGEN4_TS2 = 200;
endpackage

// File: rtl/lt_timer_ch.sv
// lt_timer_ch: one timeout channel with a saturating or auto-reload counter
module lt_timer_ch
  import lt_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             sb_clk,
  input  logic             rst,
  input  logic             slow_tick,
  input  logic             run,
  input  logic             clear,
  input  logic             tick_sel,
  input  logic             periodic,
  input  logic [CNT_W-1:0] limit,
  output logic             expired,
  output logic             pulse
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] cnt_nx;
  logic q, hit;
  // A saturated one-shot channel ignores further ticks until run or clear restarts it
  always_comb begin
    cnt_nx = {1'b0, cnt} + (CNT_W + 1)'(1);
    q = run && (tick_sel == TICK_SLOW ? slow_tick : 1'b1) && !expired;
    hit = q && (cnt_nx >= {1'b0, limit});
  end
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      expired <= 1'b0;
      pulse <= 1'b0;
    end else if (!run || clear) begin
      cnt <= '0;
      expired <= 1'b0;
      pulse <= 1'b0;
    end else if (limit == '0) begin
      expired <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= hit;
      if (hit) begin
        cnt <= periodic == MODE_PERIODIC ? '0 : limit;
        expired <= periodic != MODE_PERIODIC;
      end else if (q) cnt <= cnt_nx[CNT_W-1:0];
    end
endmodule

// File: rtl/lt_timer_bank.sv
// lt_timer_bank: NUM_CH programmable timeout channels sharing one sideband-clock prescaler
module lt_timer_bank
  import lt_timer_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W = 16,
  parameter int PRESCALE = 1000
) (
  input  logic                    sb_clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_run,
  input  logic [NUM_CH-1:0]       ch_clear,
  input  logic [NUM_CH-1:0]       ch_tick_sel,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH*CNT_W-1:0] ch_limit,
  output logic [NUM_CH-1:0]       ch_expired,
  output logic [NUM_CH-1:0]       ch_pulse,
  output logic                    slow_tick
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre;
  // slow_tick is registered one step early so it is high exactly while pre == PRESCALE-1
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      pre <= '0;
      slow_tick <= 1'b0;
    end else begin
      pre <= slow_tick ? '0 : pre + PW'(1);
      slow_tick <= pre == PW'(PRESCALE - 2);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lt_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .sb_clk(sb_clk),
      .rst(rst),
      .slow_tick(slow_tick),
      .run(ch_run[i]),
      .clear(ch_clear[i]),
      .tick_sel(ch_tick_sel[i]),
      .periodic(ch_periodic[i]),
      .limit(ch_limit[i*CNT_W +: CNT_W]),
      .expired(ch_expired[i]),
      .pulse(ch_pulse[i])
    );
  end
endmodule
